// File: rtl/shift_seq_pkg.sv
// Shared codes for the shift-register command sequencer.
package shift_pkg;

    // Command op codes
    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_SHDN = 2'b01;
    localparam logic [1:0] OP_SHUP = 2'b10;
    localparam logic [1:0] OP_ROT  = 2'b11;

    // Register mode selects {A1,A0}
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_DN   = 2'b01;
    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Register mode that carries out a given command while it runs
    function automatic logic [1:0] op_mode(input logic [1:0] op);
        case (op)
            OP_LOAD: op_mode = MODE_LOAD;
            OP_SHUP: op_mode = MODE_UP;
            default: op_mode = MODE_DN;   // SHDN and ROT both shift toward Q0
        endcase
    endfunction

endpackage

// File: rtl/shift_seq.sv
// Command sequencer driving an 8-bit universal shift register.
// One command per start/busy/done handshake; holds the register when idle.
module shift_seq
    import shift_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] op,
    input  logic [2:0] count,
    input  logic [7:0] data,
    input  logic       fill,
    input  logic [7:0] Q,
    output logic       A1,
    output logic       A0,
    output logic [7:0] D,
    output logic       DL,
    output logic       DR,
    output logic       busy,
    output logic       done
);

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  data_q, data_d;
    logic        fill_q, fill_d;
    logic [3:0]  cnt_q, cnt_d;

    // Only Q0 feeds the rotate wrap; the rest of Q is not needed here
    logic unused_q_hi;
    assign unused_q_hi = ^Q[7:1];

    // State and latched command fields
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_LOAD;
            data_q  <= 8'h00;
            fill_q  <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: accept a command in IDLE, count it down in RUN
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    op_d    = op;
                    data_d  = data;
                    fill_d  = fill;
                    if (op == OP_LOAD)
                        cnt_d = 4'd1;
                    else if (count == 3'd0)
                        cnt_d = 4'd8;
                    else
                        cnt_d = {1'b0, count};
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: mode and fill decoded from state; ROT wraps Q0 into DR
    always_comb begin
        {A1, A0} = MODE_HOLD;
        D        = 8'h00;
        DL       = 1'b0;
        DR       = 1'b0;
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        if (state_q == ST_RUN) begin
            {A1, A0} = op_mode(op_q);
            case (op_q)
                OP_LOAD: D  = data_q;
                OP_SHDN: DR = fill_q;
                OP_SHUP: DL = fill_q;
                OP_ROT:  DR = Q[0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench: shift_seq driving a behavioural universal shift register
// with Q fed back; expected results go through a scoreboard queue.
module tb_shift_seq;
    import shift_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] op    = 2'b00;
    logic [2:0] count = 3'd0;
    logic [7:0] data  = 8'h00;
    logic       fill  = 1'b0;
    logic [7:0] Q     = 8'h00;
    logic       A1, A0, DL, DR, busy, done;
    logic [7:0] D;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [7:0] q;
        int         n;
    } exp_t;
    exp_t sb[$];

    shift_seq dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .count(count),
        .data(data), .fill(fill), .Q(Q), .A1(A1), .A0(A0), .D(D),
        .DL(DL), .DR(DR), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    // Behavioural universal shift register (clear not exercised)
    always @(posedge clock) begin
        case ({A1, A0})
            2'b01:   Q <= {DR, Q[7:1]};
            2'b10:   Q <= {Q[6:0], DL};
            2'b11:   Q <= D;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        check(tag, {22'd0, A1, A0, busy, done, DL, DR, D}, 32'd0);
    endtask

    // Issue one command, watch it to done, compare against the scoreboard.
    // poke=1 pulses start once in RUN and once in DONE.
    task automatic run_cmd(input string tag, input logic [1:0] o, input logic [2:0] c,
                           input logic [7:0] d, input logic f, input logic [7:0] exp_q,
                           input bit poke);
        exp_t e;
        int n, k, mode_cyc, busy_cyc, bad;
        bit seen;
        logic [1:0] m;
        n = (o == OP_LOAD) ? 1 : ((c == 3'd0) ? 8 : int'(c));
        m = (o == OP_LOAD) ? 2'b11 : (o == OP_SHUP) ? 2'b10 : 2'b01;
        e.tag = tag; e.q = exp_q; e.n = n;
        sb.push_back(e);
        op = o; count = c; data = d; fill = f; start = 1'b1;
        k = 0; mode_cyc = 0; busy_cyc = 0; bad = 0; seen = 0;
        while (!seen && k < 20) begin
            @(negedge clock);
            k++;
            start = 1'b0;
            if (poke && k == 2) begin
                start = 1'b1; op = OP_LOAD; data = 8'hFF;
            end
            if (busy) busy_cyc++;
            if ({A1, A0} != 2'b00) begin
                mode_cyc++;
                if ({A1, A0} !== m) bad++;
                if (o == OP_LOAD && D !== d) bad++;
                if (o == OP_SHDN && DR !== f) bad++;
                if (o == OP_SHUP && DL !== f) bad++;
                if (o == OP_ROT && DR !== Q[0]) bad++;
            end
            if (done) begin
                seen = 1;
                if (poke) start = 1'b1;
            end
        end
        e = sb.pop_front();
        check({e.tag, " done_seen"}, 32'(seen), 32'd1);
        check({e.tag, " q"}, {24'd0, Q}, {24'd0, e.q});
        check({e.tag, " latency"}, k, e.n + 1);
        check({e.tag, " mode_cycles"}, mode_cyc, e.n);
        check({e.tag, " busy_cycles"}, busy_cyc, e.n + 1);
        check({e.tag, " drive_errs"}, bad, 0);
        @(negedge clock);
        start = 1'b0;
        idle_check({e.tag, " after_done"});
        if (poke) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clock);
                idle_check({e.tag, " no_queued_start"});
            end
            check({e.tag, " q_unchanged"}, {24'd0, Q}, {24'd0, e.q});
        end
    endtask

    initial begin
        // Reset, then idle
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            idle_check("reset_idle");
        end

        run_cmd("load_a5", OP_LOAD, 3'd0, 8'hA5, 1'b0, 8'hA5, 0);
        run_cmd("shdn3",   OP_SHDN, 3'd3, 8'h00, 1'b1, 8'hF4, 0);
        run_cmd("load_81", OP_LOAD, 3'd5, 8'h81, 1'b0, 8'h81, 0);
        run_cmd("shup2",   OP_SHUP, 3'd2, 8'h00, 1'b0, 8'h04, 0);
        run_cmd("load_3c", OP_LOAD, 3'd0, 8'h3C, 1'b0, 8'h3C, 0);
        run_cmd("rot8",    OP_ROT,  3'd0, 8'h00, 1'b0, 8'h3C, 0);
        run_cmd("load_01", OP_LOAD, 3'd0, 8'h01, 1'b0, 8'h01, 0);
        run_cmd("rot1",    OP_ROT,  3'd1, 8'h00, 1'b0, 8'h80, 0);
        // Starts while busy are dropped: one done, Q = 0x80 >> 4 with fill 0
        run_cmd("ignore",  OP_SHDN, 3'd4, 8'h00, 1'b0, 8'h08, 1);

        // Reset during a 5-cycle SHDN after two shifts
        op = OP_SHDN; count = 3'd5; fill = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("rst_mid run_mode", {30'd0, A1, A0}, 32'd1);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        idle_check("rst_mid idle");
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            idle_check("rst_mid no_done");
        end

        // Reset and start together: reset wins
        reset = 1'b1; start = 1'b1; op = OP_LOAD; data = 8'h55;
        @(negedge clock);
        idle_check("rst_start");
        reset = 1'b0; start = 1'b0;
        @(negedge clock);
        idle_check("rst_start after");

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
